// File: rtl/pingpong_nport_buf_pkg.sv
// Shared constants and helpers for the ping-pong N-port buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pingpong_buf_pkg;

   // Two banks: one owned by the writer, one by the reader.
   localparam int BANK_NUM = 2;

   // Bit offset of slot k on a packed bus of w-bit slots.
   function automatic int slot_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/pingpong_nport_buf_if.sv
// Handshake and data bus between the feature-map loader/window fetch and the buffer.
// Latency: n/a (wiring only).
// Backpressure: wr_ready / rd_bank_valid report bank ownership.
// Ports: write side (wr_*), shared-address read side (rd_*), debug bank indices, sticky err.
interface pingpong_nport_buf_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int PORT_NUM   = 4
);
   logic                           wr_en;
   logic [ADDR_WIDTH-1:0]          wr_addr_1P;
   logic [WIDTH-1:0]               wr_data_1P;
   logic                           wr_commit;
   logic                           wr_ready;
   logic                           rd_en;
   logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP;
   logic [PORT_NUM*WIDTH-1:0]      rd_data_NP;
   logic                           rd_data_valid;
   logic                           rd_bank_valid;
   logic                           rd_release;
   logic                           wr_bank;
   logic                           rd_bank;
   logic                           err;

   // Producer/consumer side of the buffer.
   modport master (
      output wr_en, wr_addr_1P, wr_data_1P, wr_commit, rd_en, rd_addr_NP, rd_release,
      input  wr_ready, rd_data_NP, rd_data_valid, rd_bank_valid, wr_bank, rd_bank, err
   );

   // The buffer itself.
   modport slave (
      input  wr_en, wr_addr_1P, wr_data_1P, wr_commit, rd_en, rd_addr_NP, rd_release,
      output wr_ready, rd_data_NP, rd_data_valid, rd_bank_valid, wr_bank, rd_bank, err
   );
endinterface

// File: rtl/pingpong_nport_buf_bank.sv
// dbuf_bank: DEPTH x WIDTH storage, one synchronous write port, PORT_NUM combinational read ports.
// Latency: write lands at the clock edge; reads are asynchronous index lookups.
// Backpressure: none; the caller qualifies we and range-checks addresses.
// Ports: clk, we/waddr/wdata (write), raddr (packed indices) -> rdata (packed words).
module dbuf_bank #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int IDX_W    = 5,
   parameter int PORT_NUM = 4
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [IDX_W-1:0]          waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [PORT_NUM*IDX_W-1:0] raddr,
   output logic [PORT_NUM*WIDTH-1:0] rdata
);
   import pingpong_buf_pkg::*;

   // Contents are intentionally not reset; they are don't-care until written.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   for (genvar k = 0; k < PORT_NUM; k++) begin : g_rd
      localparam int IL = slot_lsb(k, IDX_W);
      localparam int DL = slot_lsb(k, WIDTH);
      assign rdata[DL +: WIDTH] = mem[raddr[IL +: IDX_W]];
   end
endmodule

// File: rtl/pingpong_nport_buf.sv
// Ping-pong buffer: writer fills one bank while PORT_NUM readers consume the other.
// Latency: read data registered, 1 cycle after an accepted rd_en; flags update 1 cycle after commit/release.
// Backpressure: wr_ready=0 while writer bank is full; illegal strobes are dropped and set sticky err.
// Ports: clk, rst (async active-high), bus (slave modport of pingpong_nport_buf_if).
module pingpong_nport_buf #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int PORT_NUM   = 4
) (
   input logic                  clk,
   input logic                  rst,
   pingpong_nport_buf_if.slave  bus
);
   import pingpong_buf_pkg::*;

   localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

   logic [BANK_NUM-1:0]       full;
   logic                      wr_ptr;
   logic                      rd_ptr;
   logic                      err_q;
   logic [PORT_NUM*WIDTH-1:0] rd_data_q;
   logic                      rd_valid_q;

   logic                      wr_ready;
   logic                      rd_bank_valid;
   logic                      wr_in_range;
   logic                      wr_ok;
   logic                      commit_ok;
   logic                      release_ok;
   logic                      rd_ok;
   logic                      err_evt;
   logic [BANK_NUM-1:0]       full_nxt;
   logic [PORT_NUM*IDX_W-1:0] rd_idx;
   logic [PORT_NUM*WIDTH-1:0] bank0_rdata;
   logic [PORT_NUM*WIDTH-1:0] bank1_rdata;
   logic [PORT_NUM*WIDTH-1:0] rd_mux;

   assign wr_ready      = !full[wr_ptr];
   assign rd_bank_valid = full[rd_ptr];
   assign wr_in_range   = bus.wr_addr_1P < DEPTH_A;
   assign wr_ok         = bus.wr_en & wr_ready & wr_in_range;
   assign commit_ok     = bus.wr_commit & wr_ready;
   assign release_ok    = bus.rd_release & rd_bank_valid;
   assign rd_ok         = bus.rd_en & rd_bank_valid;

   // Out-of-range read addresses are benign (slot returns 0); only writer/handshake misuse is an error.
   assign err_evt = (bus.wr_en & !wr_ready)
                  | (bus.wr_en & !wr_in_range)
                  | (bus.wr_commit & !wr_ready)
                  | (bus.rd_release & !rd_bank_valid);

   // Commit needs an empty bank and release a full one, so they never touch the same bit.
   always_comb begin
      full_nxt = full;
      if (commit_ok) begin
         full_nxt[wr_ptr] = 1'b1;
      end
      if (release_ok) begin
         full_nxt[rd_ptr] = 1'b0;
      end
   end

   dbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .PORT_NUM(PORT_NUM)) u_bank0 (
      .clk   (clk),
      .we    (wr_ok & (wr_ptr == 1'b0)),
      .waddr (bus.wr_addr_1P[IDX_W-1:0]),
      .wdata (bus.wr_data_1P),
      .raddr (rd_idx),
      .rdata (bank0_rdata)
   );

   dbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .PORT_NUM(PORT_NUM)) u_bank1 (
      .clk   (clk),
      .we    (wr_ok & (wr_ptr == 1'b1)),
      .waddr (bus.wr_addr_1P[IDX_W-1:0]),
      .wdata (bus.wr_data_1P),
      .raddr (rd_idx),
      .rdata (bank1_rdata)
   );

   for (genvar k = 0; k < PORT_NUM; k++) begin : g_port
      localparam int AL = slot_lsb(k, ADDR_WIDTH);
      localparam int IL = slot_lsb(k, IDX_W);
      localparam int DL = slot_lsb(k, WIDTH);
      logic in_range;
      assign in_range             = bus.rd_addr_NP[AL +: ADDR_WIDTH] < DEPTH_A;
      assign rd_idx[IL +: IDX_W]  = bus.rd_addr_NP[AL +: IDX_W];
      assign rd_mux[DL +: WIDTH]  = !in_range ? '0
                                  : (rd_ptr ? bank1_rdata[DL +: WIDTH] : bank0_rdata[DL +: WIDTH]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full       <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         full       <= full_nxt;
         wr_ptr     <= wr_ptr ^ commit_ok;
         rd_ptr     <= rd_ptr ^ release_ok;
         err_q      <= err_q | err_evt;
         rd_valid_q <= rd_ok;
         // rd_mux was built from the pre-release rd_ptr, so a same-cycle release still reads its bank.
         if (rd_ok) begin
            rd_data_q <= rd_mux;
         end
      end
   end

   assign bus.wr_ready      = wr_ready;
   assign bus.rd_bank_valid = rd_bank_valid;
   assign bus.rd_data_NP    = rd_data_q;
   assign bus.rd_data_valid = rd_valid_q;
   assign bus.wr_bank       = wr_ptr;
   assign bus.rd_bank       = rd_ptr;
   assign bus.err           = err_q;
endmodule
